difftest_trap_monitor: RTL
==========================

# difftest_trap_monitor

Upstream producer for the difftest trap-event sink. Watches the core's commit stage and keeps free-running cycle and retired-instruction counters. It detects the simulation-trap instruction, an optional commit-stall watchdog and WFI state. Each cycle it presents a registered, sticky trap record plus an `enable` strobe that drives the trap-event DPI sink directly.

## Interface
Parameters:
- `COMMIT_W`, 2: commit ports per cycle (1..4).
- `WD_LIMIT`, 5000: consecutive commit-free cycles that fire the watchdog (≥2).

Ports:
- `clock`  in  1: core clock.
- `reset`  in  1: asynchronous, active-low reset.
- `commit_valid`  in  COMMIT_W: per-port instruction retire strobe.
- `trap_valid`  in  1: port 0 is retiring the simulation-trap instruction this cycle; only meaningful when `commit_valid[0]`=1.
- `trap_a0`  in  64: architectural a0 at the trap.
- `trap_pc`  in  64: PC of the trap instruction.
- `wfi_active`  in  1: core currently sleeping in WFI.
- `coreid`  in  8: hart id, passed through registered.
- `enable`  out  1: sink call strobe.
- `io_hasTrap`  out  1: sticky trap flag.
- `io_cycleCnt`  out  64: cycles since reset release.
- `io_instrCnt`  out  64: instructions retired.
- `io_hasWFI`  out  1: registered `wfi_active`.
- `io_code`  out  3: trap code.
- `io_pc`  out  64: trap PC.
- `io_coreid`  out  8: registered `coreid`.

## Operation
- State machine with states RUN and TRAPPED. Reset enters RUN.
- RUN behaviour:
  - `io_cycleCnt` += 1 every cycle.
  - `io_instrCnt` += popcount(`commit_valid`); the sum is zero-extended to 64 bits and wraps mod 2^64.
- Trap: `trap_valid`&&`commit_valid[0]` in RUN leads to TRAPPED next cycle, with these values latched:
  - `io_hasTrap`=1.
  - `io_code`=0 (GOOD) if `trap_a0`==0, else 1 (BAD).
  - `io_pc`=`trap_pc`.
- Commits in the trap cycle are counted in full, including the trap instruction itself.
- `trap_valid` without `commit_valid[0]` is ignored.
- TRAPPED is terminal until reset. In TRAPPED:
  - Both counters, `io_code` and `io_pc` freeze.
  - Further `trap_valid` and commits are ignored.
- `io_hasWFI` and `io_coreid` track their inputs with 1-cycle delay in both states.
- `enable`=1 every cycle after the first post-reset clock edge, in both states. The sink is responsible for stopping the simulation.

## Timing
- Reset values of all outputs are 0: `enable`, `io_hasTrap`, both counters, `io_hasWFI`, `io_code`, `io_pc`, `io_coreid`. State is RUN.
- First edge after reset release:
  - `enable`=1 and `io_cycleCnt`=1.
  - `io_instrCnt` reflects the commits sampled on that edge.
- Latency: every output is registered. An input event at edge N is visible after edge N.
- Trap at edge N gives the following at output after edge N:
  - `io_hasTrap`=1.
  - `io_cycleCnt` = its value after N, including N's increment.
  - `io_instrCnt` includes N's commits.
  - Both counters hold from that value onward.
- Reset asserted mid-operation: all state and outputs clear immediately (asynchronous), regardless of state.
- Wrap-around: `io_instrCnt` from 2^64−1 plus 2 commits yields 1. There is no saturation.

## Configuration
- `DIFFTEST_TRAP_WATCHDOG_EN` defined:
  - A stall counter (width clog2(WD_LIMIT+1)) clears on any commit, increments otherwise, and is only active in RUN.
  - When it reaches `WD_LIMIT` with no commit that cycle, the block moves to TRAPPED with `io_code`=3 (TIMEOUT) and `io_pc`=PC of the last trap_pc sample, 0 if none.
  - If a real trap and the watchdog expiry coincide, the real trap wins.
- `DIFFTEST_TRAP_WATCHDOG_EN` undefined: no stall counter, code 3 is never produced, and commit-free periods are unlimited.

## Test plan
- Reset release, `commit_valid`=2'b11 for 10 cycles → `io_instrCnt`=20, `io_cycleCnt`=10, `io_hasTrap`=0, `enable`=1 from first edge.
- Trap with `trap_a0`=0, `trap_pc`=0x8000_1234, `commit_valid`=2'b11 → next cycle `io_hasTrap`=1, `io_code`=0, `io_pc`=0x8000_1234, count includes both; counters frozen 20 cycles later.
- Trap with `trap_a0`=5 → `io_code`=1; subsequent `trap_valid` with `trap_a0`=0 → code stays 1, pc unchanged.
- `trap_valid`=1 with `commit_valid`=0 → no trap, counters keep running.
- With macro: WD_LIMIT=8, no commits for 8 cycles → `io_code`=3; a commit at stall count 7 resets the count and produces no trap. Without macro: 100 idle cycles → no trap.
- Reset asserted between edges while TRAPPED → all outputs 0 immediately; `wfi_active` toggling → `io_hasWFI` follows 1 cycle later.

Source files
------------

// File: rtl/difftest_trap_monitor.sv
// Commit-stage trap monitor feeding the difftest trap-event sink: cycle/instruction
// counters, sticky trap record, WFI and hart id. Optional stall watchdog: DIFFTEST_TRAP_WATCHDOG_EN.
module difftest_trap_monitor #(
   parameter int COMMIT_W = 2,
   parameter int WD_LIMIT = 5000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [COMMIT_W-1:0] commit_valid,
   input  logic                trap_valid,
   input  logic [63:0]         trap_a0,
   input  logic [63:0]         trap_pc,
   input  logic                wfi_active,
   input  logic [7:0]          coreid,
   output logic                enable,
   output logic                io_hasTrap,
   output logic [63:0]         io_cycleCnt,
   output logic [63:0]         io_instrCnt,
   output logic                io_hasWFI,
   output logic [2:0]          io_code,
   output logic [63:0]         io_pc,
   output logic [7:0]          io_coreid
);

   typedef enum logic {
      RUN,
      TRAPPED
   } state_e;

   localparam logic [2:0] CODE_GOOD    = 3'd0;
   localparam logic [2:0] CODE_BAD     = 3'd1;
   localparam logic [2:0] CODE_TIMEOUT = 3'd3;

   if (WD_LIMIT < 2) begin : g_bad_wd_limit
      $error("WD_LIMIT must be at least 2");
   end

   state_e      state_q, state_d;
   logic [63:0] cycle_q, cycle_d;
   logic [63:0] instr_q, instr_d;
   logic        has_trap_q, has_trap_d;
   logic [2:0]  code_q, code_d;
   logic [63:0] pc_q, pc_d;
   logic        enable_q;
   logic        wfi_q;
   logic [7:0]  coreid_q;

   logic [2:0]  commit_cnt;
   logic        commit_any;
   logic        wd_fire;
   logic [63:0] wd_pc;

   always_comb begin
      commit_cnt = 3'd0;
      for (int i = 0; i < COMMIT_W; i++) begin
         commit_cnt = commit_cnt + {2'b00, commit_valid[i]};
      end
   end

   assign commit_any = |commit_valid;

`ifdef DIFFTEST_TRAP_WATCHDOG_EN
   localparam int STALL_W = $clog2(WD_LIMIT + 1);

   logic [STALL_W-1:0] stall_q, stall_d;
   logic [63:0]        last_pc_q;

   always_comb begin
      stall_d = stall_q;
      if (state_q == RUN) begin
         stall_d = commit_any ? '0 : stall_q + 1'b1;
      end
   end

   // Expiry means this edge would be the WD_LIMIT-th consecutive commit-free one.
   assign wd_fire = (state_q == RUN) && !commit_any && (stall_q == STALL_W'(WD_LIMIT - 1));
   assign wd_pc   = last_pc_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_q   <= '0;
         last_pc_q <= '0;
      end else begin
         stall_q <= stall_d;
         if (state_q == RUN) begin
            last_pc_q <= trap_pc;
         end
      end
   end
`else
   assign wd_fire = 1'b0;
   assign wd_pc   = 64'd0;
`endif

   always_comb begin
      state_d    = state_q;
      cycle_d    = cycle_q;
      instr_d    = instr_q;
      has_trap_d = has_trap_q;
      code_d     = code_q;
      pc_d       = pc_q;
      case (state_q)
         RUN: begin
            // The trap cycle itself still counts, including the trap instruction.
            cycle_d = cycle_q + 64'd1;
            instr_d = instr_q + {61'd0, commit_cnt};
            if (trap_valid && commit_valid[0]) begin
               state_d    = TRAPPED;
               has_trap_d = 1'b1;
               code_d     = (trap_a0 == 64'd0) ? CODE_GOOD : CODE_BAD;
               pc_d       = trap_pc;
            end else if (wd_fire) begin
               state_d    = TRAPPED;
               has_trap_d = 1'b1;
               code_d     = CODE_TIMEOUT;
               pc_d       = wd_pc;
            end
         end
         TRAPPED: begin
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= RUN;
         cycle_q    <= '0;
         instr_q    <= '0;
         has_trap_q <= 1'b0;
         code_q     <= '0;
         pc_q       <= '0;
         enable_q   <= 1'b0;
         wfi_q      <= 1'b0;
         coreid_q   <= '0;
      end else begin
         state_q    <= state_d;
         cycle_q    <= cycle_d;
         instr_q    <= instr_d;
         has_trap_q <= has_trap_d;
         code_q     <= code_d;
         pc_q       <= pc_d;
         enable_q   <= 1'b1;
         wfi_q      <= wfi_active;
         coreid_q   <= coreid;
      end
   end

   assign enable      = enable_q;
   assign io_hasTrap  = has_trap_q;
   assign io_cycleCnt = cycle_q;
   assign io_instrCnt = instr_q;
   assign io_hasWFI   = wfi_q;
   assign io_code     = code_q;
   assign io_pc       = pc_q;
   assign io_coreid   = coreid_q;

endmodule
